// File: rtl/controle_pc.sv
// controle_pc: next-PC sequencer and req/ack instruction-fetch controller.
// Define CONTROLE_PC_PERF_EN to add Taken_Count / Timeout_Count perf ports.
module controle_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [3:0]  MAX_WAIT = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] Branch_Target,
  input  logic        Stall,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Pc,
`ifdef CONTROLE_PC_PERF_EN
  output logic [15:0] Taken_Count,
  output logic [7:0]  Timeout_Count,
`endif
  output logic        Timeout_Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  wait_cnt, cnt_nx;
  logic [31:0] pc_nx, instr_nx;
  logic        req_nx, valid_nx, err_nx;
  logic        accept, taken, timeout;

  assign accept  = (state == S_OUT) & Instr_Valid
                 & Instr_Ready & !Stall;
  assign taken   = Branch & Zero;
  // An ack in the expiring cycle wins over the timeout.
  assign timeout = (state == S_WAIT) & !Imem_Ack
                 & (wait_cnt == MAX_WAIT - 4'd1);

  assign Imem_Addr = Pc;

  always_comb begin
    state_nx = state;
    cnt_nx   = wait_cnt;
    pc_nx    = Pc;
    req_nx   = Imem_Req;
    instr_nx = Instr;
    valid_nx = Instr_Valid;
    err_nx   = Timeout_Err;
    unique case (state)
      S_IDLE: begin
        if (!Stall) state_nx = S_REQ;
      end
      S_REQ: begin
        req_nx   = 1'b1;
        cnt_nx   = 4'd0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (Imem_Ack) begin
          instr_nx = Imem_Data;
          valid_nx = 1'b1;
          req_nx   = 1'b0;
          state_nx = S_OUT;
        end else if (timeout) begin
          req_nx   = 1'b0;
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = wait_cnt + 4'd1;
        end
      end
      S_OUT: begin
        if (accept) begin
          valid_nx = 1'b0;
          pc_nx    = taken ? (Branch_Target & 32'hFFFF_FFFC)
                           : Pc + PC_STEP;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      Pc          <= RESET_PC;
      Imem_Req    <= 1'b0;
      Instr       <= 32'h0;
      Instr_Valid <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= cnt_nx;
      Pc          <= pc_nx;
      Imem_Req    <= req_nx;
      Instr       <= instr_nx;
      Instr_Valid <= valid_nx;
      Timeout_Err <= err_nx;
    end
  end

`ifdef CONTROLE_PC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Taken_Count   <= 16'h0;
      Timeout_Count <= 8'h0;
    end else begin
      if (accept && taken && Taken_Count != 16'hFFFF)
        Taken_Count <= Taken_Count + 16'd1;
      if (timeout && Timeout_Count != 8'hFF)
        Timeout_Count <= Timeout_Count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_controle_pc.sv
// tb_controle_pc: directed stimulus against a transaction-level fetch model.
// Covers optional perf ports when CONTROLE_PC_PERF_EN is defined.
module tb_controle_pc;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] Branch_Target = 32'h0;
  logic        Stall = 1'b0;
  logic        Imem_Ack = 1'b0;
  logic [31:0] Imem_Data = 32'h0;
  logic        Instr_Ready = 1'b0;
  logic        Imem_Req, Instr_Valid, Timeout_Err;
  logic [31:0] Imem_Addr, Instr, Pc;
`ifdef CONTROLE_PC_PERF_EN
  logic [15:0] Taken_Count;
  logic [7:0]  Timeout_Count;
`endif

  controle_pc dut (
    .clk(clk),
    .rst_n(rst_n),
    .Branch(Branch),
    .Zero(Zero),
    .Branch_Target(Branch_Target),
    .Stall(Stall),
    .Imem_Req(Imem_Req),
    .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack),
    .Imem_Data(Imem_Data),
    .Instr(Instr),
    .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready),
    .Pc(Pc),
`ifdef CONTROLE_PC_PERF_EN
    .Taken_Count(Taken_Count),
    .Timeout_Count(Timeout_Count),
`endif
    .Timeout_Err(Timeout_Err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: m_go = fetch pending, m_req = waiting on memory,
  // m_valid = word held for decoder
  bit          m_go, m_req, m_valid, m_err;
  int          m_wait, m_taken, m_to;
  logic [31:0] m_pc, m_instr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_go = 0; m_req = 0; m_valid = 0; m_err = 0;
    m_wait = 0; m_taken = 0; m_to = 0;
    m_pc = 32'h0; m_instr = 32'h0;
  endtask

  task automatic model_step();
    if (m_valid) begin
      if (Instr_Ready && !Stall) begin
        m_valid = 0;
        m_go = 1;
        if (Branch && Zero) begin
          m_pc = {Branch_Target[31:2], 2'b00};
          if (m_taken < 65535) m_taken++;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (m_req) begin
      if (Imem_Ack) begin
        m_instr = Imem_Data;
        m_valid = 1;
        m_req = 0;
      end else if (m_wait == MW - 1) begin
        m_req = 0;
        m_err = 1;
        if (m_to < 255) m_to++;
      end else begin
        m_wait++;
      end
    end else if (m_go) begin
      m_req = 1;
      m_wait = 0;
      m_go = 0;
    end else if (!Stall) begin
      m_go = 1;
    end
  endtask

  task automatic compare();
    chk("pc", Pc, m_pc);
    chk("addr", Imem_Addr, m_pc);
    chk("req", {31'b0, Imem_Req}, {31'b0, m_req});
    chk("valid", {31'b0, Instr_Valid}, {31'b0, m_valid});
    chk("instr", Instr, m_instr);
    chk("terr", {31'b0, Timeout_Err}, {31'b0, m_err});
`ifdef CONTROLE_PC_PERF_EN
    chk("taken_cnt", {16'b0, Taken_Count}, m_taken);
    chk("to_cnt", {24'b0, Timeout_Count}, m_to);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare();
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    Imem_Ack = 0;
    while (!m_req && n < 20) begin
      cyc();
      n++;
    end
    n_chk++;
    if (!m_req) begin
      n_err++;
      $display("FAIL wait_req: no request in %0d cycles", n);
    end
  endtask

  task automatic fetch(input logic [31:0] d, input int dly,
                       input int hold, input int stl,
                       input bit br, input bit z,
                       input logic [31:0] tg);
    wait_req();
    Stall = (dly > 0);
    repeat (dly) cyc();
    Stall = 0;
    Imem_Ack = 1; Imem_Data = d;
    cyc();
    Instr_Ready = 0;
    Imem_Data = ~d;
    Branch = 1; Zero = 1; Branch_Target = 32'h100;
    repeat (hold) cyc();
    Imem_Ack = 0;
    Instr_Ready = 1; Stall = 1;
    repeat (stl) cyc();
    Stall = 0;
    Branch = br; Zero = z; Branch_Target = tg;
    cyc();
    Instr_Ready = 0; Branch = 0; Zero = 0;
    Branch_Target = 32'hDEAD_BEE0;
  endtask

  initial begin
    model_reset();
    repeat (2) cyc();
    chk("rst_pc", Pc, 32'h0);
    chk("rst_req", {31'b0, Imem_Req}, 32'h0);
    chk("rst_valid", {31'b0, Instr_Valid}, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_terr", {31'b0, Timeout_Err}, 32'h0);
    #2 rst_n = 1;

    cyc(); cyc();
    chk("lat_req", {31'b0, Imem_Req}, 32'h1);
    chk("lat_addr", Imem_Addr, 32'h0);
    Imem_Ack = 1; Imem_Data = 32'h8C01_0004;
    cyc();
    Imem_Ack = 0;
    chk("lat_valid", {31'b0, Instr_Valid}, 32'h1);
    chk("lat_instr", Instr, 32'h8C01_0004);
    Instr_Ready = 1;
    cyc();
    Instr_Ready = 0;
    chk("seq_4", Pc, 32'h4);
    fetch(32'h8C01_0004, 0, 0, 0, 0, 0, 32'h0);
    chk("seq_8", Pc, 32'h8);

    fetch(32'h1111_0000, 0, 1, 0, 1, 1, 32'h10);
    chk("br_10", Pc, 32'h10);
    fetch(32'h1111_0001, 0, 0, 0, 1, 1, 32'h40);
    chk("br_taken", Pc, 32'h40);
    fetch(32'h1111_0002, 2, 0, 0, 1, 1, 32'h10);
    fetch(32'h1111_0003, 0, 0, 0, 1, 0, 32'h40);
    chk("br_not_taken", Pc, 32'h14);
    fetch(32'h1111_0004, 0, 0, 0, 1, 1, 32'h43);
    chk("br_align", Pc, 32'h40);

    fetch(32'h2222_0000, MW - 1, 0, 0, 0, 0, 32'h0);
    chk("late_ack_terr", {31'b0, Timeout_Err}, 32'h0);
    chk("late_ack_pc", Pc, 32'h44);

    wait_req();
    repeat (MW) cyc();
    chk("to_terr", {31'b0, Timeout_Err}, 32'h1);
    chk("to_req", {31'b0, Imem_Req}, 32'h0);
    chk("to_pc", Pc, 32'h44);
    Stall = 1;
    repeat (3) cyc();
    chk("idle_stall_req", {31'b0, Imem_Req}, 32'h0);
    Stall = 0;
    fetch(32'h3333_0000, 0, 0, 0, 0, 0, 32'h0);
    chk("retry_pc", Pc, 32'h48);

    fetch(32'h4444_0000, 0, 5, 2, 0, 0, 32'h0);
    chk("stall_pc", Pc, 32'h4C);

    fetch(32'h5555_0000, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("pre_wrap", Pc, 32'hFFFF_FFFC);
    fetch(32'h5555_0001, 0, 0, 0, 0, 0, 32'h0);
    chk("wrap", Pc, 32'h0);
    chk("terr_sticky", {31'b0, Timeout_Err}, 32'h1);
`ifdef CONTROLE_PC_PERF_EN
    chk("perf_taken", {16'b0, Taken_Count}, 32'd5);
    chk("perf_to", {24'b0, Timeout_Count}, 32'd1);
`endif

    wait_req();
    cyc();
    rst_n = 0;
    #1;
    chk("arst_req", {31'b0, Imem_Req}, 32'h0);
    chk("arst_valid", {31'b0, Instr_Valid}, 32'h0);
    chk("arst_pc", Pc, 32'h0);
    chk("arst_terr", {31'b0, Timeout_Err}, 32'h0);
    model_reset();
    Imem_Ack = 1; Imem_Data = 32'h6666_0000;
    cyc();
    #2 rst_n = 1;
    cyc();
    Imem_Ack = 0;
    cyc();
    chk("post_rst_valid", {31'b0, Instr_Valid}, 32'h0);
    chk("post_rst_instr", Instr, 32'h0);
    fetch(32'h7777_0000, 0, 0, 0, 0, 0, 32'h0);
    chk("post_rst_pc", Pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
